pixel_arbiter: RTL and testbench

//  Shares one sprite BRAM read port between N_SPRITES blob units. Each 25 MHz pixel slot it takes the

---
 rtl/pixel_arbiter_pkg.sv | 33 +++
 rtl/pixel_arbiter_layer_priority_sel.sv | 46 ++++
 rtl/pixel_arbiter.sv | 168 ++++++++++++++++
 tb/tb_pixel_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : pixel_arbiter_pkg
//  Brief   : Shared widths, layer encoding, FSM states and helpers for the
//            sprite BRAM pixel arbiter.
//  Rev     : 1.0  initial release
// ============================================================================
package pixel_arbiter_pkg;

    localparam int          c_ADDR_W     = 16;
    localparam int          c_RGB_W      = 12;
    localparam int          c_LAYER_W    = 2;
    localparam logic [1:0]  c_LAYER_TOP  = 2'd3;
    localparam logic [11:0] c_TRANSP_KEY = 12'hF0F;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_CAPTURE = 2'd3
    } arb_state_t;

    function automatic logic [3:0] f_popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_arbiter_layer_priority_sel.sv
`default_nettype none
// ============================================================================
//  Module  : layer_priority_sel
//  Brief   : Picks the pending requester on the highest layer (lowest index on
//            a tie) and flags slots with two or more pending requesters.
//  Rev     : 1.0  initial release
// ============================================================================
module layer_priority_sel
    import pixel_arbiter_pkg::*;
#(
    parameter int N_SPRITES = 4,
    parameter int IDX_W     = 2
)(
    input  logic [N_SPRITES-1:0]           i_pending,
    input  logic [N_SPRITES*c_LAYER_W-1:0] i_layers,
    output logic [IDX_W-1:0]               o_winner,
    output logic                           o_valid,
    output logic                           o_multi
);

    logic [7:0] w_pend8;

    always_comb begin
        w_pend8                  = '0;
        w_pend8[N_SPRITES-1:0]   = i_pending;
    end

    // Layer-major search: the first requester found on the top-most occupied layer wins.
    always_comb begin
        o_winner = '0;
        o_valid  = 1'b0;
        for (int l = int'(c_LAYER_TOP); l >= 0; l--) begin
            for (int i = 0; i < N_SPRITES; i++) begin
                if (!o_valid && i_pending[i] &&
                    (i_layers[i*c_LAYER_W +: c_LAYER_W] == c_LAYER_W'(l))) begin
                    o_winner = IDX_W'(i);
                    o_valid  = 1'b1;
                end
            end
        end
    end

    assign o_multi = (f_popcount8(w_pend8) >= 4'd2);

endmodule
`default_nettype wire

// File: rtl/pixel_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : pixel_arbiter
//  Brief   : Shares one sprite BRAM read port between blob units per pixel
//            slot and drives the composited pixel to the VGA output stage.
//  Rev     : 1.0  initial release
// ============================================================================
module pixel_arbiter
    import pixel_arbiter_pkg::*;
#(
    parameter int               N_SPRITES   = 4,
    parameter int               ADDR_W      = c_ADDR_W,
    parameter int               RGB_W       = c_RGB_W,
    parameter int               RAM_LATENCY = 1,
    parameter logic [RGB_W-1:0] TRANSP_KEY  = RGB_W'(c_TRANSP_KEY)
)(
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          clk25en,
    input  logic [N_SPRITES-1:0]          request,
    input  logic [N_SPRITES*ADDR_W-1:0]   address_in,
    input  logic [N_SPRITES*2-1:0]        layer_in,
    input  logic                          blank,
    input  logic [RGB_W-1:0]              bg_color,
    output logic                          ram_en,
    output logic [ADDR_W-1:0]             ram_addr,
    input  logic [RGB_W-1:0]              ram_data,
    output logic [RGB_W-1:0]              pixel_rgb,
    output logic                          collision,
    output logic [N_SPRITES-1:0]          collision_mask,
    input  logic                          collision_clr
);

    localparam int c_IDX_W = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1;

    arb_state_t                     r_state;
    logic                           r_reissue;
    logic [N_SPRITES-1:0]           r_pending;
    logic [ADDR_W-1:0]              r_addr  [N_SPRITES];
    logic [c_LAYER_W-1:0]           r_layer [N_SPRITES];
    logic [RGB_W-1:0]               r_hold_rgb;
    logic                           r_ram_en;
    logic [ADDR_W-1:0]              r_ram_addr;
    logic [RGB_W-1:0]               r_pixel_rgb;
    logic                           r_collision;
    logic [N_SPRITES-1:0]           r_collision_mask;

    logic [N_SPRITES-1:0]           w_pend;
    logic [ADDR_W-1:0]              w_addr  [N_SPRITES];
    logic [N_SPRITES*c_LAYER_W-1:0] w_layers;
    logic [c_IDX_W-1:0]             w_win_idx;
    logic                           w_win_valid;
    logic                           w_multi;
    logic [N_SPRITES-1:0]           w_new_coll;

    // A request arriving with clk25en belongs to the slot being closed, so bypass the latches.
    assign w_pend = r_pending | request;

    for (genvar i = 0; i < N_SPRITES; i++) begin : g_req
        assign w_addr[i] = request[i] ? address_in[i*ADDR_W +: ADDR_W] : r_addr[i];
        assign w_layers[i*c_LAYER_W +: c_LAYER_W] =
            request[i] ? layer_in[i*2 +: 2] : r_layer[i];
    end

    layer_priority_sel #(
        .N_SPRITES (N_SPRITES),
        .IDX_W     (c_IDX_W)
    ) u_sel (
        .i_pending (w_pend),
        .i_layers  (w_layers),
        .o_winner  (w_win_idx),
        .o_valid   (w_win_valid),
        .o_multi   (w_multi)
    );

    assign w_new_coll = (!blank && w_multi) ? w_pend : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_SPRITES; i++) begin
                r_addr[i]  <= '0;
                r_layer[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_SPRITES; i++) begin
                if (request[i]) begin
                    r_addr[i]  <= address_in[i*ADDR_W +: ADDR_W];
                    r_layer[i] <= layer_in[i*2 +: 2];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= ST_IDLE;
            r_reissue        <= 1'b0;
            r_pending        <= '0;
            r_hold_rgb       <= '0;
            r_ram_en         <= 1'b0;
            r_ram_addr       <= '0;
            r_pixel_rgb      <= '0;
            r_collision      <= 1'b0;
            r_collision_mask <= '0;
        end else begin
            r_ram_en    <= 1'b0;
            r_collision <= 1'b0;
            if (clk25en) begin
                r_pending        <= '0;
                r_pixel_rgb      <= r_hold_rgb;
                r_collision      <= !blank && w_multi;
                r_collision_mask <= (collision_clr ? '0 : r_collision_mask) | w_new_coll;
                r_reissue        <= 1'b0;
                if (blank) begin
                    r_hold_rgb <= '0;
                    r_state    <= ST_IDLE;
                end else if (w_win_valid) begin
                    r_ram_addr <= w_addr[w_win_idx];
                    // A slot closing mid-ISSUE defers the new read one cycle so ram_en never doubles up.
                    if (r_ram_en) begin
                        r_reissue <= 1'b1;
                        r_state   <= ST_WAIT;
                    end else begin
                        r_ram_en  <= 1'b1;
                        r_state   <= ST_ISSUE;
                    end
                end else begin
                    r_hold_rgb <= bg_color;
                    r_state    <= ST_IDLE;
                end
            end else begin
                r_pending <= r_pending | request;
                if (collision_clr) begin
                    r_collision_mask <= '0;
                end
                case (r_state)
                    ST_ISSUE: begin
                        r_state <= (RAM_LATENCY > 1) ? ST_WAIT : ST_CAPTURE;
                    end
                    ST_WAIT: begin
                        if (r_reissue) begin
                            r_ram_en  <= 1'b1;
                            r_reissue <= 1'b0;
                            r_state   <= ST_ISSUE;
                        end else begin
                            r_state   <= ST_CAPTURE;
                        end
                    end
                    ST_CAPTURE: begin
                        r_hold_rgb <= (ram_data == TRANSP_KEY) ? bg_color : ram_data;
                        r_state    <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign ram_en         = r_ram_en;
    assign ram_addr       = r_ram_addr;
    assign pixel_rgb      = r_pixel_rgb;
    assign collision      = r_collision;
    assign collision_mask = r_collision_mask;

endmodule
`default_nettype wire

// File: tb/tb_pixel_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_pixel_arbiter
//  Brief   : Self-checking bench for pixel_arbiter at RAM latency 1 and 2
//            driven side by side against a slot-level reference model.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_pixel_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int CW = 12;
    localparam logic [CW-1:0] BG = 12'h00A;

    logic              clk           = 1'b0;
    logic              reset_n       = 1'b0;
    logic              clk25en       = 1'b0;
    logic              blank         = 1'b0;
    logic              collision_clr = 1'b0;
    logic [N-1:0]      request       = '0;
    logic [N*AW-1:0]   address_in    = '0;
    logic [N*2-1:0]    layer_in      = '0;
    logic [CW-1:0]     bg_color      = BG;

    logic              ram_en1, ram_en2, col1, col2;
    logic [AW-1:0]     ram_addr1, ram_addr2;
    logic [CW-1:0]     ram_data1, ram_data2, pix1, pix2;
    logic [N-1:0]      mask1, mask2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pixel_arbiter #(.N_SPRITES(N), .ADDR_W(AW), .RGB_W(CW), .RAM_LATENCY(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .clk25en(clk25en), .request(request),
        .address_in(address_in), .layer_in(layer_in), .blank(blank), .bg_color(bg_color),
        .ram_en(ram_en1), .ram_addr(ram_addr1), .ram_data(ram_data1), .pixel_rgb(pix1),
        .collision(col1), .collision_mask(mask1), .collision_clr(collision_clr)
    );

    pixel_arbiter #(.N_SPRITES(N), .ADDR_W(AW), .RGB_W(CW), .RAM_LATENCY(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .clk25en(clk25en), .request(request),
        .address_in(address_in), .layer_in(layer_in), .blank(blank), .bg_color(bg_color),
        .ram_en(ram_en2), .ram_addr(ram_addr2), .ram_data(ram_data2), .pixel_rgb(pix2),
        .collision(col2), .collision_mask(mask2), .collision_clr(collision_clr)
    );

    // Sprite memory contents: a few fixed pixels, a transparent pattern, otherwise a hash.
    function automatic logic [CW-1:0] ram_val(input logic [AW-1:0] a);
        if (a == 16'h0010) return 12'h123;
        if (a[3:0] == 4'hF) return 12'hF0F;
        return a[11:0] ^ a[15:4] ^ 12'h5A5;
    endfunction

    logic [CW-1:0] r1_q = 12'hBAD;
    logic [CW-1:0] r2_a = 12'hBAD;
    logic [CW-1:0] r2_q = 12'hBAD;
    always @(posedge clk) begin
        if (ram_en1) r1_q <= ram_val(ram_addr1);
        if (ram_en2) r2_a <= ram_val(ram_addr2);
        r2_q <= r2_a;
    end
    assign ram_data1 = r1_q;
    assign ram_data2 = r2_q;

    // Reference model state
    logic [CW-1:0] m_shown = '0;
    logic [CW-1:0] m_next  = '0;
    logic [N-1:0]  m_mask  = '0;
    logic [AW-1:0] m_addr  = '0;

    logic [N-1:0]  s_req  [4];
    logic [AW-1:0] s_addr [4][N];
    logic [1:0]    s_lay  [4][N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic en, input logic col);
        chk({tag, " ram_en/L1"},   32'(ram_en1),   32'(en));
        chk({tag, " ram_en/L2"},   32'(ram_en2),   32'(en));
        chk({tag, " ram_addr/L1"}, 32'(ram_addr1), 32'(m_addr));
        chk({tag, " ram_addr/L2"}, 32'(ram_addr2), 32'(m_addr));
        chk({tag, " pixel/L1"},    32'(pix1),      32'(m_shown));
        chk({tag, " pixel/L2"},    32'(pix2),      32'(m_shown));
        chk({tag, " coll/L1"},     32'(col1),      32'(col));
        chk({tag, " coll/L2"},     32'(col2),      32'(col));
        chk({tag, " mask/L1"},     32'(mask1),     32'(m_mask));
        chk({tag, " mask/L2"},     32'(mask2),     32'(m_mask));
    endtask

    task automatic clear_stim();
        for (int c = 0; c < 4; c++) begin
            s_req[c] = '0;
            for (int b = 0; b < N; b++) begin
                s_addr[c][b] = 16'($urandom);
                s_lay[c][b]  = 2'($urandom_range(3, 0));
            end
        end
    endtask

    task automatic put_req(input int c, input int b, input logic [AW-1:0] a, input logic [1:0] l);
        s_req[c][b]  = 1'b1;
        s_addr[c][b] = a;
        s_lay[c][b]  = l;
    endtask

    // One pixel slot of four clocks, clk25en on the last; clr_c < 0 means no clear.
    task automatic run_slot(input string tag, input logic blk, input int clr_c);
        logic [N-1:0]  pend;
        logic [AW-1:0] fa [N];
        logic [1:0]    fl [N];
        logic [CW-1:0] rv;
        logic          issue, coll;
        int            best;
        pend = '0;
        for (int b = 0; b < N; b++) begin
            fa[b] = '0;
            fl[b] = '0;
        end
        for (int c = 0; c < 4; c++) begin
            for (int b = 0; b < N; b++) begin
                if (s_req[c][b]) begin
                    pend[b] = 1'b1;
                    fa[b]   = s_addr[c][b];
                    fl[b]   = s_lay[c][b];
                end
            end
        end
        best = -1;
        for (int l = 3; l >= 0; l--) begin
            for (int b = 0; b < N; b++) begin
                if (best < 0 && pend[b] && fl[b] == 2'(l)) best = b;
            end
        end
        issue = !blk && (best >= 0);
        coll  = !blk && ($countones(pend) >= 2);
        for (int c = 0; c < 4; c++) begin
            request = s_req[c];
            for (int b = 0; b < N; b++) begin
                address_in[b*AW +: AW] = s_addr[c][b];
                layer_in[b*2 +: 2]     = s_lay[c][b];
            end
            clk25en       = (c == 3);
            blank         = blk;
            collision_clr = (c == clr_c);
            @(posedge clk);
            #1;
            if (c == clr_c) m_mask = '0;
            if (c == 3) begin
                m_shown = m_next;
                if (coll)  m_mask = m_mask | pend;
                if (issue) m_addr = fa[best];
                if (blk) begin
                    m_next = '0;
                end else if (best < 0) begin
                    m_next = BG;
                end else begin
                    rv     = ram_val(fa[best]);
                    m_next = (rv == 12'hF0F) ? BG : rv;
                end
            end
            check_outputs(tag, (c == 3) && issue, (c == 3) && coll);
        end
        request       = '0;
        clk25en       = 1'b0;
        collision_clr = 1'b0;
        blank         = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset", 1'b0, 1'b0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        clear_stim(); put_req(1, 1, 16'h0010, 2'd2);
        run_slot("single", 1'b0, -1);
        clear_stim();
        run_slot("empty", 1'b0, -1);
        clear_stim(); put_req(0, 0, 16'h0100, 2'd1); put_req(2, 2, 16'h0200, 2'd3);
        run_slot("priority", 1'b0, -1);
        clear_stim(); put_req(1, 1, 16'h0111, 2'd2); put_req(1, 3, 16'h0333, 2'd2);
        run_slot("tie", 1'b0, 0);
        clear_stim(); put_req(2, 3, 16'h002F, 2'd0);
        run_slot("transp", 1'b0, -1);
        clear_stim(); put_req(3, 0, 16'h0010, 2'd0);
        run_slot("coincident", 1'b0, -1);
        clear_stim(); put_req(0, 0, 16'h0100, 2'd3); put_req(1, 1, 16'h0200, 2'd1);
        run_slot("blank", 1'b1, -1);
        clear_stim(); put_req(0, 2, 16'h0600, 2'd1); put_req(3, 3, 16'h0700, 2'd1);
        run_slot("clr_vs_new", 1'b0, 3);
        clear_stim(); put_req(0, 2, 16'h0300, 2'd3); put_req(2, 2, 16'h0400, 2'd0);
        put_req(1, 1, 16'h0500, 2'd1);
        run_slot("last_wins", 1'b0, -1);
        clear_stim(); put_req(0, 2, 16'h0777, 2'd1);
        run_slot("pre_reset", 1'b0, -1);

        // Reset lands while the L1 unit captures and the L2 unit is waiting on the RAM.
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        m_shown = '0; m_next = '0; m_mask = '0; m_addr = '0;
        check_outputs("async_reset", 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        clear_stim();
        run_slot("post_reset_empty", 1'b0, -1);
        clear_stim(); put_req(2, 1, 16'h0010, 2'd0);
        run_slot("post_reset_req", 1'b0, -1);
        clear_stim();
        run_slot("post_reset_show", 1'b0, -1);

        for (int s = 0; s < 40; s++) begin
            int c0;
            clear_stim();
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(1, 0) == 1) begin
                    c0 = int'($urandom_range(3, 0));
                    put_req(c0, b, 16'($urandom), 2'($urandom_range(3, 0)));
                    if (c0 < 3 && $urandom_range(3, 0) == 0)
                        put_req(int'($urandom_range(3, c0 + 1)), b, 16'($urandom),
                                2'($urandom_range(3, 0)));
                end
            end
            run_slot("random", $urandom_range(7, 0) == 0,
                     ($urandom_range(3, 0) == 0) ? int'($urandom_range(3, 0)) : -1);
        end
        clear_stim();
        run_slot("flush", 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
